booth_pp_gen: RTL and testbench

- Upstream feeder of the per-bit Wallace slices in the 16x16 signed radix-4 Booth multiplier.
- Captures operands X and Y through a valid/ready handshake and Booth-encodes Y into 8 partial products of 32 bits.
- Transposes the partial products into 32 eight-bit columns, one column per tree slice.
- Emits the 8 negation carries: bits [5:0] go to slice 0 cin; bits 7:6 go to the final carry-propagate adder.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/booth_sel.sv | 47 ++++
 rtl/booth_pp_gen.sv | 72 +++++++
 tb/tb_booth_pp_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants for the 16x16 radix-4 Booth multiplier
package mult_pkg;

  localparam int WIDTH = 16;
  localparam int NPP   = WIDTH / 2;
  localparam int PP_W  = 2 * WIDTH;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_X    = 2'd1,
    SEL_2X   = 2'd2
  } sel_e;

  // Column j of the transposed bus holds bit j of every partial product.
  localparam int NCOL  = PP_W;
  localparam int COL_W = NPP;

  function automatic int col_lsb(input int j);
    return j * COL_W;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// rtl/booth_sel.sv - one radix-4 Booth group: triplet and X to a 32-bit partial product
module booth_sel #(
  parameter int IDX = 0
) (
  input  logic [2:0]                 trip,
  input  logic [mult_pkg::WIDTH-1:0] x,
  output logic [mult_pkg::PP_W-1:0]  pp,
  output logic                       neg
);
  import mult_pkg::*;

  sel_e             sel;
  logic [WIDTH:0]   mag;
  logic [PP_W-1:0]  base;

  always_comb begin
    sel = SEL_ZERO;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: sel = SEL_X;
      3'b011:         sel = SEL_2X;
      3'b100: begin
        sel = SEL_2X;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        sel = SEL_X;
        neg = 1'b1;
      end
      default: ;
    endcase
  end

  // 2X is built one bit wider than X so -32768*2 keeps its sign.
  always_comb begin
    case (sel)
      SEL_X:   mag = {x[WIDTH-1], x};
      SEL_2X:  mag = {x, 1'b0};
      default: mag = '0;
    endcase
  end

  // Complementing all 32 bits puts every +1 carry at weight 2^0.
  assign base = {{(PP_W-WIDTH-1){mag[WIDTH]}}, mag} << (2 * IDX);
  assign pp   = neg ? ~base : base;

endmodule

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - two-stage Booth encoder feeding transposed columns to the Wallace slices
module booth_pp_gen #(
  parameter int  WIDTH = 16,
  localparam int NPP   = WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH*NPP-1:0]   col_pp,
  output logic [NPP-1:0]           neg
);
  import mult_pkg::*;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s2_adv;
  logic [WIDTH:0]   y_ext;

  logic [PP_W-1:0]        pp [NPP];
  logic [NPP-1:0]         neg_next;
  logic [2*WIDTH*NPP-1:0] col_next;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign y_ext    = {s1_y, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_grp
    booth_sel #(.IDX(i)) u_sel (
      .trip (y_ext[2*i+2:2*i]),
      .x    (s1_x),
      .pp   (pp[i]),
      .neg  (neg_next[i])
    );
    for (genvar j = 0; j < NCOL; j++) begin : g_col
      assign col_next[col_lsb(j)+i] = pp[i][j];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_x <= x;
      s1_y <= y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      col_pp    <= '0;
      neg       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          col_pp <= col_next;
          neg    <= neg_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// tb/tb_booth_pp_gen.sv - directed and scoreboard checks of the Booth partial-product feeder
module tb_booth_pp_gen;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  x;
  logic [15:0]  y;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] col_pp;
  logic [7:0]   neg;

  int checks;
  int failures;

  booth_pp_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .col_pp    (col_pp),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pp_of(input logic [255:0] c, input int i);
    logic [31:0] r;
    for (int j = 0; j < 32; j++) r[j] = c[8*j+i];
    return r;
  endfunction

  function automatic logic [31:0] col_of(input logic [255:0] c, input int j);
    return 32'(c[8*j +: 8]);
  endfunction

  function automatic logic [31:0] total(input logic [255:0] c, input logic [7:0] n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 8; i++) s = s + pp_of(c, i) + 32'(n[i]);
    return s;
  endfunction

  function automatic logic [31:0] prod(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return p;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         output logic [255:0] c, output logic [7:0] n);
    apply_reset();
    check("vec_rdy", 32'(in_ready), 32'd1);
    x        = a;
    y        = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("vec_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("vec_lat2", 32'(out_valid), 32'd1);
    c = col_pp;
    n = neg;
  endtask

  localparam int NRAND = 500;

  logic [255:0] c;
  logic [7:0]   n;
  logic [255:0] snap;
  logic [7:0]   snapn;
  logic         seen;
  logic [31:0]  q[$];
  logic [31:0]  e;
  int           sent;
  int           got;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    #12;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_col", 32'(col_pp != '0), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);

    run_vec(16'd3, 16'd5, c, n);
    check("v1_pp0", pp_of(c, 0), 32'd3);
    check("v1_pp1", pp_of(c, 1), 32'd12);
    for (int i = 2; i < 8; i++) check("v1_ppz", pp_of(c, i), 32'd0);
    check("v1_neg", 32'(n), 32'h00);
    check("v1_col0", col_of(c, 0), 32'h01);
    check("v1_col2", col_of(c, 2), 32'h02);
    check("v1_col3", col_of(c, 3), 32'h02);
    check("v1_tot", total(c, n), 32'd15);

    run_vec(16'd7, 16'hFFFF, c, n);
    check("v2_pp0", pp_of(c, 0), 32'hFFFFFFF8);
    for (int i = 1; i < 8; i++) check("v2_ppz", pp_of(c, i), 32'd0);
    check("v2_neg", 32'(n), 32'h01);
    check("v2_tot", total(c, n), 32'hFFFFFFF9);

    run_vec(16'd1, 16'd2, c, n);
    check("v3_pp0", pp_of(c, 0), 32'hFFFFFFFD);
    check("v3_pp1", pp_of(c, 1), 32'd4);
    check("v3_neg", 32'(n), 32'h01);
    check("v3_tot", total(c, n), 32'd2);

    run_vec(16'h8000, 16'h8000, c, n);
    check("v4_tot", total(c, n), 32'h40000000);

    // Backpressure: three pairs against a stalled output.
    apply_reset();
    out_ready = 1'b0;
    x = 16'd100; y = 16'hFFFD; in_valid = 1'b1;
    check("bp_rdy_a", 32'(in_ready), 32'd1);
    @(negedge clk);
    x = 16'h7FFF; y = 16'h7FFF;
    check("bp_rdy_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    x = 16'h8000; y = 16'd1;
    check("bp_rdy_c", 32'(in_ready), 32'd0);
    check("bp_ov", 32'(out_valid), 32'd1);
    snap  = col_pp;
    snapn = neg;
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_ov", 32'(out_valid), 32'd1);
      check("bp_hold_col", 32'(col_pp == snap), 32'd1);
      check("bp_hold_neg", 32'(neg), 32'(snapn));
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check("bp_out_a", total(col_pp, neg), 32'hFFFFFED4);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_ov_b", 32'(out_valid), 32'd1);
    check("bp_out_b", total(col_pp, neg), 32'h3FFF0001);
    @(negedge clk);
    check("bp_ov_c", 32'(out_valid), 32'd1);
    check("bp_out_c", total(col_pp, neg), 32'hFFFF8000);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset while a result is stalled and another is queued.
    apply_reset();
    out_ready = 1'b0;
    x = 16'd5; y = 16'd6; in_valid = 1'b1;
    @(negedge clk);
    x = 16'd9; y = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_ov_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ov", 32'(out_valid), 32'd0);
    check("mr_col", 32'(col_pp != '0), 32'd0);
    check("mr_neg", 32'(neg), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("mr_stale", 32'(seen), 32'd0);
    check("mr_rdy", 32'(in_ready), 32'd1);

    // Random valid/ready traffic against a product scoreboard.
    apply_reset();
    sent = 0;
    got  = 0;
    q.delete();
    for (int cyc = 0; cyc < 5000 && (sent < NRAND || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (sent < NRAND) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x = 16'($urandom);
        y = 16'($urandom);
        case ($urandom_range(0, 7))
          0: x = 16'h8000;
          1: y = 16'h8000;
          2: y = 16'hFFFF;
          default: ;
        endcase
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (sent >= NRAND) || ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(prod(x, y));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rnd_prod", total(col_pp, neg), e);
        end
        got++;
      end
    end
    check("rnd_sent", 32'(sent), 32'(NRAND));
    check("rnd_left", 32'(q.size()), 32'd0);
    check("rnd_got", 32'(got), 32'(NRAND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
